// File: rtl/hdmi_display_top.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_display_top
// Description : DVI/HDMI colour-bar source with TMDS encode and serialiser,
//               running entirely on the TMDS bit clock (pixel = sys_clk / 10).
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_display_top #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic sys_clk,
    input  logic sys_rst,
    output logic tmds_data_0_p,
    output logic tmds_data_0_n,
    output logic tmds_data_1_p,
    output logic tmds_data_1_n,
    output logic tmds_data_2_p,
    output logic tmds_data_2_n,
    output logic tmds_clk_p,
    output logic tmds_clk_n
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_hw      = $clog2(c_h_total + 1);
    localparam int c_vw      = $clog2(c_v_total + 1);

    localparam logic [c_hw-1:0] c_h_last  = c_hw'(c_h_total - 1);
    localparam logic [c_hw-1:0] c_h_act   = c_hw'(H_ACTIVE);
    localparam logic [c_hw-1:0] c_h_ss    = c_hw'(H_ACTIVE + H_FP);
    localparam logic [c_hw-1:0] c_h_se    = c_hw'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_hw-1:0] c_h_bar_w = c_hw'(H_ACTIVE / 8);
    localparam logic [c_hw-1:0] c_h_one   = c_hw'(1);
    localparam logic [c_vw-1:0] c_v_last  = c_vw'(c_v_total - 1);
    localparam logic [c_vw-1:0] c_v_act   = c_vw'(V_ACTIVE);
    localparam logic [c_vw-1:0] c_v_ss    = c_vw'(V_ACTIVE + V_FP);
    localparam logic [c_vw-1:0] c_v_se    = c_vw'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [c_vw-1:0] c_v_one   = c_vw'(1);

    localparam logic [3:0] c_div_last  = 4'd9;
    localparam logic [9:0] c_clk_word  = 10'b0000011111;

    // Returns {new_disparity[4:0], tmds_word[9:0]} for one active pixel byte.
    function automatic logic [14:0] tmds_encode(input logic [7:0] d,
                                                input logic signed [4:0] disp);
        logic [8:0] q_m;
        logic [9:0] q_out;
        logic       use_xnor;
        int         n1d;
        int         n1q;
        int         n0q;
        int         acc;
        n1d = 0;
        for (int i = 0; i < 8; i++) if (d[i]) n1d++;
        use_xnor = (n1d > 4) || ((n1d == 4) && !d[0]);
        q_m = '0;
        q_m[0] = d[0];
        for (int i = 1; i < 8; i++)
            q_m[i] = use_xnor ? ~(q_m[i-1] ^ d[i]) : (q_m[i-1] ^ d[i]);
        q_m[8] = ~use_xnor;
        n1q = 0;
        for (int i = 0; i < 8; i++) if (q_m[i]) n1q++;
        n0q = 8 - n1q;
        acc = int'(disp);
        if ((acc == 0) || (n1q == n0q)) begin
            q_out = {~q_m[8], q_m[8], (q_m[8] ? q_m[7:0] : ~q_m[7:0])};
            acc   = q_m[8] ? acc + (n1q - n0q) : acc + (n0q - n1q);
        end else if (((acc > 0) && (n1q > n0q)) || ((acc < 0) && (n0q > n1q))) begin
            q_out = {1'b1, q_m[8], ~q_m[7:0]};
            acc   = acc + (q_m[8] ? 2 : 0) + (n0q - n1q);
        end else begin
            q_out = {1'b0, q_m[8], q_m[7:0]};
            acc   = acc - (q_m[8] ? 0 : 2) + (n1q - n0q);
        end
        return {5'(acc), q_out};
    endfunction

    function automatic logic [9:0] ctrl_word(input logic [1:0] c);
        logic [9:0] w;
        case (c)
            2'b00:   w = 10'h354;
            2'b01:   w = 10'h0AB;
            2'b10:   w = 10'h154;
            default: w = 10'h2AB;
        endcase
        return w;
    endfunction

    logic [3:0]       r_div;
    logic [c_hw-1:0]  r_h_cnt;
    logic [c_vw-1:0]  r_v_cnt;
    logic [2:0][9:0]  r_enc;
    logic [2:0][4:0]  r_disp;
    logic [2:0][9:0]  r_shift;
    logic [9:0]       r_clk_shift;

    logic             w_tick;
    logic             w_de;
    logic             w_hsync;
    logic             w_vsync;
    logic [2:0]       w_bar;
    logic [2:0][7:0]  w_data;
    logic [2:0][9:0]  w_ctrl_word;
    logic [2:0][9:0]  w_word_nxt;
    logic [2:0][4:0]  w_disp_nxt;

    assign w_tick  = (r_div == c_div_last);
    assign w_de    = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
    assign w_hsync = ((r_h_cnt >= c_h_ss) && (r_h_cnt < c_h_se)) ? SYNC_POL : ~SYNC_POL;
    assign w_vsync = ((r_v_cnt >= c_v_ss) && (r_v_cnt < c_v_se)) ? SYNC_POL : ~SYNC_POL;
    assign w_bar   = 3'(r_h_cnt / c_h_bar_w);

    // Bar order white..black makes each component a single inverted bar bit.
    always_comb begin
        w_data      = '0;
        w_ctrl_word = '0;
        w_word_nxt  = '0;
        w_disp_nxt  = '0;
        w_data[0]   = {8{~w_bar[0]}};
        w_data[1]   = {8{~w_bar[2]}};
        w_data[2]   = {8{~w_bar[1]}};
        w_ctrl_word[0] = ctrl_word({w_vsync, w_hsync});
        w_ctrl_word[1] = ctrl_word(2'b00);
        w_ctrl_word[2] = ctrl_word(2'b00);
        for (int i = 0; i < 3; i++)
            {w_disp_nxt[i], w_word_nxt[i]} = tmds_encode(w_data[i], $signed(r_disp[i]));
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_div   <= '0;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_tick) begin
            r_div <= '0;
            if (r_h_cnt == c_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + c_v_one;
            end else begin
                r_h_cnt <= r_h_cnt + c_h_one;
            end
        end else begin
            r_div <= r_div + 4'd1;
        end
    end

    // Shift regs take the previous encoded word, giving a two-period latency.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_enc       <= '0;
            r_disp      <= '0;
            r_shift     <= '0;
            r_clk_shift <= '0;
        end else if (w_tick) begin
            r_shift     <= r_enc;
            r_clk_shift <= c_clk_word;
            for (int i = 0; i < 3; i++) begin
                if (w_de) begin
                    r_enc[i]  <= w_word_nxt[i];
                    r_disp[i] <= w_disp_nxt[i];
                end else begin
                    r_enc[i]  <= w_ctrl_word[i];
                    r_disp[i] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < 3; i++)
                r_shift[i] <= {1'b0, r_shift[i][9:1]};
            r_clk_shift <= {1'b0, r_clk_shift[9:1]};
        end
    end

    assign tmds_data_0_p = r_shift[0][0];
    assign tmds_data_0_n = ~r_shift[0][0];
    assign tmds_data_1_p = r_shift[1][0];
    assign tmds_data_1_n = ~r_shift[1][0];
    assign tmds_data_2_p = r_shift[2][0];
    assign tmds_data_2_n = ~r_shift[2][0];
    assign tmds_clk_p    = r_clk_shift[0];
    assign tmds_clk_n    = ~r_clk_shift[0];

endmodule
`default_nettype wire

// File: tb/tb_hdmi_display_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdmi_display_top
// Description : Directed bench for hdmi_display_top on a 24x8 tiny raster;
//               lanes are deserialised using the clock-lane framing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_display_top;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic d0p, d0n, d1p, d1n, d2p, d2n, ckp, ckn;

    int n_checks = 0;
    int n_fail   = 0;
    int n_words  = 0;
    int n_pn_bad = 0;
    int bidx     = 10;
    logic prev_clk = 1'b0;
    logic [9:0] acc0, acc1, acc2;
    logic [9:0] cap [0:2][0:1023];

    hdmi_display_top #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(4),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .tmds_data_0_p(d0p),
        .tmds_data_0_n(d0n),
        .tmds_data_1_p(d1p),
        .tmds_data_1_n(d1n),
        .tmds_data_2_p(d2p),
        .tmds_data_2_n(d2n),
        .tmds_clk_p   (ckp),
        .tmds_clk_n   (ckn)
    );

    always #5 sys_clk = ~sys_clk;

    // Deserialiser: a word starts on each 0->1 of the clock lane, LSB first.
    always @(negedge sys_clk) begin
        if ({d0n, d1n, d2n, ckn} !== ~{d0p, d1p, d2p, ckp}) n_pn_bad++;
        if (sys_rst) begin
            n_words  = 0;
            bidx     = 10;
            prev_clk = 1'b0;
        end else begin
            if (ckp && !prev_clk) bidx = 0;
            if (bidx < 10) begin
                acc0[bidx] = d0p;
                acc1[bidx] = d1p;
                acc2[bidx] = d2p;
                bidx++;
                if (bidx == 10 && n_words < 1024) begin
                    cap[0][n_words] = acc0;
                    cap[1][n_words] = acc1;
                    cap[2][n_words] = acc2;
                    n_words++;
                end
            end
            prev_clk = ckp;
        end
    end

    task automatic wait_words(input int n);
        int budget;
        budget = 0;
        while (n_words < n && budget < 5000) begin
            @(negedge sys_clk);
            budget++;
        end
        n_checks++;
        if (n_words < n) begin
            n_fail++;
            $display("FAIL wait_words: got %0d words, expected at least %0d", n_words, n);
        end
    endtask

    task automatic test_reset();
        logic [7:0] got;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        got = {d0p, d1p, d2p, ckp, d0n, d1n, d2n, ckn};
        n_checks++;
        if (got[7:4] !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_p: got %b expected 0000", got[7:4]);
        end
        n_checks++;
        if (got[3:0] !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_n: got %b expected 1111", got[3:0]);
        end
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
    endtask

    task automatic test_clock_lane();
        int  k;
        logic exp_b;
        k = 0;
        @(negedge sys_clk);
        while (!ckp && k < 20) begin
            @(negedge sys_clk);
            k++;
        end
        n_checks++;
        if (!ckp) begin
            n_fail++;
            $display("FAIL clk_start: got %b expected 1 within 20 cycles", ckp);
        end
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge sys_clk);
            exp_b = (c % 10) < 5;
            n_checks++;
            if (ckp !== exp_b) begin
                n_fail++;
                $display("FAIL clk_pattern[%0d]: got %b expected %b", c, ckp, exp_b);
            end
        end
    endtask

    // Pixels (h,0) h=0..4: white, white, yellow, yellow, cyan.
    task automatic test_first_pixels();
        logic [9:0] exp_tab [0:4][0:2];
        exp_tab[0] = '{10'h200, 10'h200, 10'h200};
        exp_tab[1] = '{10'h0FF, 10'h0FF, 10'h0FF};
        exp_tab[2] = '{10'h3FF, 10'h0FF, 10'h0FF};
        exp_tab[3] = '{10'h100, 10'h200, 10'h200};
        exp_tab[4] = '{10'h200, 10'h0FF, 10'h3FF};
        wait_words(6);
        n_checks++;
        if (cap[0][0] !== 10'h000) begin
            n_fail++;
            $display("FAIL first_word: got %h expected 000", cap[0][0]);
        end
        for (int p = 0; p < 5; p++) begin
            for (int l = 0; l < 3; l++) begin
                n_checks++;
                if (cap[l][p+1] !== exp_tab[p][l]) begin
                    n_fail++;
                    $display("FAIL pixel(%0d,0) lane%0d: got %h expected %h",
                             p, l, cap[l][p+1], exp_tab[p][l]);
                end
            end
        end
    endtask

    task automatic test_porches();
        logic [9:0] exp0;
        wait_words(26);
        for (int h = 16; h < 24; h++) begin
            exp0 = (h >= 18 && h < 22) ? 10'h154 : 10'h2AB;
            n_checks++;
            if (cap[0][h+1] !== exp0) begin
                n_fail++;
                $display("FAIL hblank h=%0d lane0: got %h expected %h", h, cap[0][h+1], exp0);
            end
            for (int l = 1; l < 3; l++) begin
                n_checks++;
                if (cap[l][h+1] !== 10'h354) begin
                    n_fail++;
                    $display("FAIL hblank h=%0d lane%0d: got %h expected 354", h, l, cap[l][h+1]);
                end
            end
        end
        for (int l = 0; l < 3; l++) begin
            n_checks++;
            if (cap[l][25] !== 10'h200) begin
                n_fail++;
                $display("FAIL pixel(0,1) lane%0d: got %h expected 200", l, cap[l][25]);
            end
        end
    endtask

    task automatic test_vsync();
        int         pos [0:5];
        logic [9:0] exp0 [0:5];
        pos  = '{73, 97, 121, 139, 150, 169};
        exp0 = '{10'h200, 10'h2AB, 10'h0AB, 10'h354, 10'h0AB, 10'h2AB};
        wait_words(170);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (cap[0][pos[i]] !== exp0[i]) begin
                n_fail++;
                $display("FAIL vert word%0d lane0: got %h expected %h", pos[i], cap[0][pos[i]], exp0[i]);
            end
        end
        n_checks++;
        if (cap[2][150] !== 10'h354) begin
            n_fail++;
            $display("FAIL vsync lane2: got %h expected 354", cap[2][150]);
        end
    endtask

    task automatic test_second_frame();
        int         pos [0:3];
        logic [9:0] exp0 [0:3];
        pos  = '{193, 194, 211, 313};
        exp0 = '{10'h200, 10'h0FF, 10'h154, 10'h0AB};
        wait_words(314);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (cap[0][pos[i]] !== exp0[i]) begin
                n_fail++;
                $display("FAIL frame2 word%0d lane0: got %h expected %h", pos[i], cap[0][pos[i]], exp0[i]);
            end
        end
        n_checks++;
        if (cap[1][193] !== 10'h200) begin
            n_fail++;
            $display("FAIL frame2 pixel(0,0) lane1: got %h expected 200", cap[1][193]);
        end
    endtask

    task automatic test_reset_midline();
        repeat (37) @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        @(posedge sys_clk);
        @(posedge sys_clk);
        @(negedge sys_clk);
        n_checks++;
        if ({d0p, d1p, d2p, ckp} !== 4'b0000) begin
            n_fail++;
            $display("FAIL midreset_p: got %b expected 0000", {d0p, d1p, d2p, ckp});
        end
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        wait_words(3);
        for (int l = 0; l < 3; l++) begin
            n_checks++;
            if (cap[l][1] !== 10'h200) begin
                n_fail++;
                $display("FAIL restart pixel(0,0) lane%0d: got %h expected 200", l, cap[l][1]);
            end
            n_checks++;
            if (cap[l][2] !== 10'h0FF) begin
                n_fail++;
                $display("FAIL restart pixel(1,0) lane%0d: got %h expected 0FF", l, cap[l][2]);
            end
        end
    endtask

    task automatic test_diff_pairs();
        n_checks++;
        if (n_pn_bad !== 0) begin
            n_fail++;
            $display("FAIL diff_pairs: got %0d bad cycles expected 0", n_pn_bad);
        end
    endtask

    initial begin
        test_reset();
        test_clock_lane();
        test_first_pixels();
        test_porches();
        test_vsync();
        test_second_frame();
        test_reset_midline();
        test_diff_pairs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
